i2s_adc_receiver: RTL

- Capture side of the audio codec path: deserialises the codec's I2S ADC stream (ADCDAT, framed by ADCLRCK and BCLK) into 16-bit left and right samples.
- Presents each channel as an Avalon-ST source with valid/ready, buffered in a small per-channel FIFO.
- Sits beside the DAC sink path in the audio subsystem, with the codec clocked by the audio PLL output.
- BCLK, ADCLRCK and ADCDAT are treated as asynchronous inputs and oversampled in the system clock domain.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_sample_fifo.sv | 69 ++++++
 rtl/i2s_adc_receiver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Types and constants shared by the audio capture path.
//   AUDIO_SAMPLE_W : default sample width, in bits
//   rx_state_t     : I2S receiver slot-tracking FSM states
//   channel_t      : stereo channel that a captured word belongs to
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    typedef enum logic [1:0] {
        SYNC_WAIT,  // waiting for the first slot boundary after reset
        DELAY,      // I2S one-bit delay slot, data not yet valid
        SHIFT,      // shifting sample bits in, MSB first
        HOLD        // word captured, ignoring the rest of the slot
    } rx_state_t;

    typedef enum logic {
        CH_LEFT,
        CH_RIGHT
    } channel_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous single-clock FIFO that buffers samples for one channel.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset. Empties the FIFO.
//   push_i      : write push_data_i. It is ignored when the FIFO is full and no
//                 pop occurs in the same cycle.
//   push_data_i : sample to write
//   pop_i       : remove the head entry. It is ignored when the FIFO is empty.
//   full_o      : DEPTH entries are held
//   empty_o     : no entries are held
//   head_o      : oldest entry. It reads 0 while the FIFO is empty.
// DEPTH must be a power of two, so the pointers wrap without extra compare logic.
// -----------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset. The count and pointers define which
    // entries are valid, and head_o is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/i2s_adc_receiver.sv
// -----------------------------------------------------------------------------
// i2s_adc_receiver
// Deserialises the codec I2S ADC stream into left and right samples. Each
// channel is presented as an Avalon-ST source with its own FIFO.
//   clk_clk, reset_reset                  : system clock, sync active-high reset
//   audio_in_external_interface_BCLK      : codec bit clock (asynchronous)
//   audio_in_external_interface_ADCLRCK   : codec word select (asynchronous)
//   audio_in_external_interface_ADCDAT    : codec serial data (asynchronous)
//   audio_in_avalon_{left,right}_channel_source_{data,valid,ready}
//                                         : per-channel sample sources
//   overflow                              : 1-cycle pulse, sample dropped on full FIFO
//   frame_error                           : 1-cycle pulse, slot ended mid-word
// clk_clk must run at 4x BCLK or faster. The codec pins are oversampled.
// -----------------------------------------------------------------------------
module i2s_adc_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH      = AUDIO_SAMPLE_W,
    parameter int FIFO_DEPTH      = 4,
    parameter bit LEFT_LRCK_LEVEL = 1'b0
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  audio_in_external_interface_BCLK,
    input  logic                  audio_in_external_interface_ADCLRCK,
    input  logic                  audio_in_external_interface_ADCDAT,
    output logic [DATA_WIDTH-1:0] audio_in_avalon_left_channel_source_data,
    output logic                  audio_in_avalon_left_channel_source_valid,
    input  logic                  audio_in_avalon_left_channel_source_ready,
    output logic [DATA_WIDTH-1:0] audio_in_avalon_right_channel_source_data,
    output logic                  audio_in_avalon_right_channel_source_valid,
    input  logic                  audio_in_avalon_right_channel_source_ready,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Input synchronisers. BCLK has an extra history flop for edge detection.
    logic bclk_meta_q, bclk_sync_q, bclk_hist_q;
    logic lrck_meta_q, lrck_sync_q;
    logic dat_meta_q,  dat_sync_q;

    // Slot-tracking FSM state
    rx_state_t             state_q;
    channel_t              ch_q;
    logic                  primed_q;
    logic                  last_lrck_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  push_q;
    logic                  frame_error_q;
    logic                  overflow_q;

    logic     bclk_rise;
    logic     slot_start;
    channel_t slot_ch;

    // FIFO interface
    logic push_l, push_r, pop_l, pop_r;
    logic full_l, full_r, empty_l, empty_r;

    // NOTE: every sequential block uses non-blocking assignments, so each flop
    // captures the value its source had before the clock edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_hist_q <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            dat_meta_q  <= 1'b0;
            dat_sync_q  <= 1'b0;
        end else begin
            bclk_meta_q <= audio_in_external_interface_BCLK;
            bclk_sync_q <= bclk_meta_q;
            bclk_hist_q <= bclk_sync_q;
            lrck_meta_q <= audio_in_external_interface_ADCLRCK;
            lrck_sync_q <= lrck_meta_q;
            dat_meta_q  <= audio_in_external_interface_ADCDAT;
            dat_sync_q  <= dat_meta_q;
        end
    end

    assign bclk_rise = bclk_sync_q & ~bclk_hist_q;
    // The first rise after reset only learns the current word-select level.
    // Without this, a right slot already in progress at reset would be seen as a
    // new slot start, and its tail would be captured as a truncated word.
    assign slot_start = primed_q & (lrck_sync_q != last_lrck_q);
    assign slot_ch    = (lrck_sync_q == LEFT_LRCK_LEVEL) ? CH_LEFT : CH_RIGHT;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= SYNC_WAIT;
            ch_q          <= CH_LEFT;
            primed_q      <= 1'b0;
            last_lrck_q   <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
            if (bclk_rise) begin
                last_lrck_q <= lrck_sync_q;
                primed_q    <= 1'b1;
                if (slot_start) begin
                    // A boundary before the LSB arrived drops the partial word.
                    if (state_q == SHIFT || state_q == DELAY) frame_error_q <= 1'b1;
                    state_q <= DELAY;
                    ch_q    <= slot_ch;
                end else begin
                    case (state_q)
                        // The slot-start rise carried the delay bit. This rise
                        // carries the MSB, so the register restarts with it.
                        DELAY: begin
                            shift_q   <= {{(DATA_WIDTH-1){1'b0}}, dat_sync_q};
                            bit_cnt_q <= CNT_W'(1);
                            state_q   <= SHIFT;
                        end
                        SHIFT: begin
                            shift_q   <= {shift_q[DATA_WIDTH-2:0], dat_sync_q};
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= HOLD;
                                push_q  <= 1'b1;
                            end
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end
        end
    end

    assign push_l = push_q & (ch_q == CH_LEFT);
    assign push_r = push_q & (ch_q == CH_RIGHT);
    assign pop_l  = ~empty_l & audio_in_avalon_left_channel_source_ready;
    assign pop_r  = ~empty_r & audio_in_avalon_right_channel_source_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) overflow_q <= 1'b0;
        else overflow_q <= (push_l & full_l & ~pop_l) | (push_r & full_r & ~pop_r);
    end

    audio_sample_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_left (
        .clk_i       (clk_clk),
        .rst_i       (reset_reset),
        .push_i      (push_l),
        .push_data_i (shift_q),
        .pop_i       (pop_l),
        .full_o      (full_l),
        .empty_o     (empty_l),
        .head_o      (audio_in_avalon_left_channel_source_data)
    );

    audio_sample_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_right (
        .clk_i       (clk_clk),
        .rst_i       (reset_reset),
        .push_i      (push_r),
        .push_data_i (shift_q),
        .pop_i       (pop_r),
        .full_o      (full_r),
        .empty_o     (empty_r),
        .head_o      (audio_in_avalon_right_channel_source_data)
    );

    assign audio_in_avalon_left_channel_source_valid  = ~empty_l;
    assign audio_in_avalon_right_channel_source_valid = ~empty_r;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule
